mac_accumulator: RTL



---
 rtl/mac_pkg.sv | 24 ++
 rtl/sat_add.sv | 38 +++
 rtl/mac_accumulator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared definitions for the MAC datapath: default datapath widths
//            (common to the multiplier, accumulator and writeback stage) and
//            the accumulator control-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Default widths shared across the MAC datapath.
  localparam int unsigned MAC_PROD_W = 32;  // 16x16 multiplier output width
  localparam int unsigned MAC_ACC_W  = 40;  // accumulator width (> product width)
  localparam int unsigned MAC_CNT_W  = 8;   // beat-count field width

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mac_state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Purpose  : Combinational unsigned saturating adder. Adds a zero-extended
//            PROD_W-bit addend to an ACC_W-bit accumulator value; if the
//            ACC_W-bit sum carries out, the result clamps to all-ones.
// Ports    : acc    in  ACC_W   current accumulator value
//            addend in  PROD_W  unsigned addend
//            sum    out ACC_W   saturated sum
//            sat    out 1       high when the sum was clamped
// Revision : 1.0 - initial release
// ============================================================================
module sat_add
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = MAC_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // One extra bit captures the carry-out of the ACC_W-bit addition.
  logic [ACC_W:0]   raw_sum;
  logic [ACC_W-1:0] addend_ext;

  assign addend_ext = {{(ACC_W - PROD_W){1'b0}}, addend};
  assign raw_sum    = {1'b0, acc} + {1'b0, addend_ext};

  // Inputs are non-negative, so an all-ones accumulator either stays all-ones
  // (addend 0) or carries out and clamps back to all-ones.
  assign sat = raw_sum[ACC_W];
  assign sum = sat ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];

endmodule : sat_add
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Purpose  : Accumulates a run-time-programmed number of unsigned products
//            into a saturating wide accumulator and presents the dot-product
//            result over a valid/ready handshake.
// Ports    : clk       in  1       system clock (rising edge)
//            rst_n     in  1       asynchronous active-low reset
//            start     in  1       begin a new accumulation (sampled in IDLE)
//            len       in  CNT_W   number of products (sampled with start)
//            in_valid  in  1       product beat valid
//            in_ready  out 1       product accepted this cycle
//            prod      in  PROD_W  unsigned product
//            out_valid out 1       result valid
//            out_ready in  1       downstream accepts the result
//            acc_out   out ACC_W   accumulated sum
//            ovf       out 1       sticky saturation flag for this result
//            busy      out 1       high while accumulating or holding result
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = MAC_PROD_W,
  parameter int unsigned ACC_W  = MAC_ACC_W,
  parameter int unsigned CNT_W  = MAC_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic             beat;

  sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (prod),
    .sum    (add_sum),
    .sat    (add_sat)
  );

  // in_ready_q is a registered decode of ACCUM, so this is the handshake.
  assign beat = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          // An empty dot product goes straight to DONE with a zero result.
          state_d = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end

      ST_ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_sat;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state and registered, so they
  // depend only on the current state and never on in_valid/out_ready.
  always_comb begin
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_ACCUM) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // The accumulator only changes on accepted beats or a start in IDLE, so it
  // is held stable throughout DONE.
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule : mac_accumulator
`default_nettype wire
